// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - shared types for the shared register arbiter
package shared_reg_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority picker
// The first set request at or after ptr (wrapping modulo N) wins.
module rr_priority_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                         = 1'b1;
                idx                         = PW'((int'(ptr) + k) % N);
                onehot[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin ownership arbiter owning a shared register
// One owner at a time, bounded by MAX_HOLD; handoff happens without an idle gap.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4,
    localparam int PW = $clog2(N),
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    wr_en,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [PW-1:0]   owner_id,
    output logic            busy,
    output logic [W-1:0]    result,
    output logic            result_valid
);
    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [HW-1:0] hold;

    logic [PW-1:0] next_owner;
    logic [PW-1:0] pick_ptr;
    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic          hold_limit;
    logic          release_now;
    logic [W-1:0]  owner_data;

    assign next_owner  = (owner_id == PW'(N - 1)) ? '0 : owner_id + 1'b1;
    // While owned, the picker already looks from the post-release pointer so a handoff is immediate.
    assign pick_ptr    = (state == ST_OWNED) ? next_owner : rr_ptr;
    assign hold_limit  = (MAX_HOLD != 0) && (hold == HW'(MAX_HOLD - 1));
    assign release_now = !req[owner_id] || hold_limit;
    assign owner_data  = wdata[int'(owner_id) * W +: W];

    rr_priority_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            hold         <= '0;
            gnt          <= '0;
            owner_id     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            result_valid <= 1'b0;
            if (pick_any) begin
                state    <= ST_OWNED;
                gnt      <= pick_onehot;
                owner_id <= pick_idx;
                hold     <= '0;
                busy     <= 1'b1;
            end
        end else begin
            if (wr_en[owner_id]) begin
                result       <= owner_data;
                result_valid <= 1'b1;
            end else begin
                result_valid <= 1'b0;
            end
            if (release_now) begin
                rr_ptr <= next_owner;
                if (pick_any) begin
                    gnt      <= pick_onehot;
                    owner_id <= pick_idx;
                    hold     <= '0;
                end else begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            end else if (!(&hold)) begin
                hold <= hold + 1'b1;
            end
        end
    end
endmodule
